// File: rtl/fused_fp_add_issue.sv
// Operand issue stage for the fused multi-precision FP adder: a 2-entry
// valid/ready buffer that classifies every lane of both operands at push.
module fused_fp_add_issue #(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned FP32_WIDTH = 32,
  localparam int unsigned CONFIG_WIDTH = 3,
  localparam int unsigned ROUND_TYPE_WIDTH = 3
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        SYNC_CLR,
  input  logic                        IN_VALID,
  output logic                        IN_READY,
  input  logic [FP32_WIDTH-1:0]       IN1,
  input  logic [FP32_WIDTH-1:0]       IN2,
  input  logic [CONFIG_WIDTH-1:0]     CONFIG_FP,
  input  logic [ROUND_TYPE_WIDTH-1:0] ROUND_TYPE,
  output logic                        OUT_VALID,
  input  logic                        OUT_READY,
  output logic [FP32_WIDTH-1:0]       OUT_IN1,
  output logic [FP32_WIDTH-1:0]       OUT_IN2,
  output logic [CONFIG_WIDTH-1:0]     OUT_CONFIG,
  output logic [ROUND_TYPE_WIDTH-1:0] OUT_ROUND,
  output logic [3:0]                  OUT_LANE_MASK,
  output logic [7:0]                  OUT_ZERO,
  output logic [7:0]                  OUT_SUBN,
  output logic [7:0]                  OUT_INF,
  output logic [7:0]                  OUT_NAN
);

  localparam logic [CONFIG_WIDTH-1:0] CFG_FP16 = 3'd1;
  localparam logic [CONFIG_WIDTH-1:0] CFG_BF16 = 3'd2;
  localparam logic [CONFIG_WIDTH-1:0] CFG_E4M3 = 3'd3;
  localparam logic [CONFIG_WIDTH-1:0] CFG_E5M2 = 3'd4;

  typedef struct packed {
    logic [FP32_WIDTH-1:0]       in1;
    logic [FP32_WIDTH-1:0]       in2;
    logic [CONFIG_WIDTH-1:0]     cfg;
    logic [ROUND_TYPE_WIDTH-1:0] rnd;
    logic [3:0]                  mask;
    logic [7:0]                  zero;
    logic [7:0]                  subn;
    logic [7:0]                  inf;
    logic [7:0]                  nan;
  } issue_entry_t;

  typedef struct packed {
    logic [3:0] zero;
    logic [3:0] subn;
    logic [3:0] inf;
    logic [3:0] nan;
  } lane_flags_t;

  // Per-lane class as {nan, inf, subn, zero}; E4M3 has no infinity and only S.1111.111 is NaN.
  function automatic logic [3:0] lane_cls(input logic e_ones, input logic e_zero,
                                          input logic m_zero, input logic m_ones,
                                          input logic e4m3);
    lane_cls = 4'b0000;
    if (e_zero) begin
      lane_cls = m_zero ? 4'b0001 : 4'b0010;
    end else if (e_ones) begin
      if (e4m3) lane_cls = m_ones ? 4'b1000 : 4'b0000;
      else      lane_cls = m_zero ? 4'b0100 : 4'b1000;
    end
  endfunction

  function automatic lane_flags_t classify(input logic [FP32_WIDTH-1:0] x,
                                           input logic [CONFIG_WIDTH-1:0] cfg);
    logic [3:0] c [4];
    logic [7:0] b;
    for (int i = 0; i < 4; i++) c[i] = 4'b0000;
    case (cfg)
      CFG_FP16: begin
        c[0] = lane_cls(&x[14:10], ~|x[14:10], ~|x[9:0], &x[9:0], 1'b0);
        c[2] = lane_cls(&x[30:26], ~|x[30:26], ~|x[25:16], &x[25:16], 1'b0);
      end
      CFG_BF16: begin
        c[0] = lane_cls(&x[14:7], ~|x[14:7], ~|x[6:0], &x[6:0], 1'b0);
        c[2] = lane_cls(&x[30:23], ~|x[30:23], ~|x[22:16], &x[22:16], 1'b0);
      end
      CFG_E4M3: begin
        for (int i = 0; i < 4; i++) begin
          b = x[8*i +: 8];
          c[i] = lane_cls(&b[6:3], ~|b[6:3], ~|b[2:0], &b[2:0], 1'b1);
        end
      end
      CFG_E5M2: begin
        for (int i = 0; i < 4; i++) begin
          b = x[8*i +: 8];
          c[i] = lane_cls(&b[6:2], ~|b[6:2], ~|b[1:0], &b[1:0], 1'b0);
        end
      end
      default: c[0] = lane_cls(&x[30:23], ~|x[30:23], ~|x[22:0], &x[22:0], 1'b0);
    endcase
    for (int i = 0; i < 4; i++) begin
      classify.nan[i]  = c[i][3];
      classify.inf[i]  = c[i][2];
      classify.subn[i] = c[i][1];
      classify.zero[i] = c[i][0];
    end
  endfunction

  function automatic logic [3:0] lane_mask(input logic [CONFIG_WIDTH-1:0] cfg);
    case (cfg)
      CFG_FP16, CFG_BF16: lane_mask = 4'b0101;
      CFG_E4M3, CFG_E5M2: lane_mask = 4'b1111;
      default:            lane_mask = 4'b0001;
    endcase
  endfunction

  issue_entry_t head, tail, new_entry;
  lane_flags_t  f1_c, f2_c;
  logic [1:0]   occ, occ_nxt;
  logic         out_valid, in_ready;
  logic         push, pop, load_head, load_tail, head_from_tail;

  // Entry built from the upstream operands, classified before it is stored.
  always_comb begin
    f1_c = classify(IN1, CONFIG_FP);
    f2_c = classify(IN2, CONFIG_FP);
    new_entry      = '0;
    new_entry.in1  = IN1;
    new_entry.in2  = IN2;
    new_entry.cfg  = CONFIG_FP;
    new_entry.rnd  = ROUND_TYPE;
    new_entry.mask = lane_mask(CONFIG_FP);
    new_entry.zero = {f2_c.zero, f1_c.zero};
    new_entry.subn = {f2_c.subn, f1_c.subn};
    new_entry.inf  = {f2_c.inf,  f1_c.inf};
    new_entry.nan  = {f2_c.nan,  f1_c.nan};
  end

  // Occupancy / head-tail steering; head is always the registered output entry.
  always_comb begin
    push           = IN_VALID & in_ready;
    pop            = out_valid & OUT_READY;
    occ_nxt        = occ;
    load_head      = 1'b0;
    load_tail      = 1'b0;
    head_from_tail = 1'b0;
    case (occ)
      2'd0: begin
        if (push) begin
          load_head = 1'b1;
          occ_nxt   = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          load_head = 1'b1;
        end else if (push) begin
          load_tail = 1'b1;
          occ_nxt   = 2'd2;
        end else if (pop) begin
          occ_nxt = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          load_head      = 1'b1;
          head_from_tail = 1'b1;
          occ_nxt        = 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head      <= '0;
      tail      <= '0;
      occ       <= 2'd0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else if (SYNC_CLR) begin
      occ       <= 2'd0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      occ       <= occ_nxt;
      out_valid <= (occ_nxt != 2'd0);
      in_ready  <= (occ_nxt < 2'(DEPTH));
      if (load_head) head <= head_from_tail ? tail : new_entry;
      if (load_tail) tail <= new_entry;
    end
  end

  assign IN_READY      = in_ready;
  assign OUT_VALID     = out_valid;
  assign OUT_IN1       = head.in1;
  assign OUT_IN2       = head.in2;
  assign OUT_CONFIG    = head.cfg;
  assign OUT_ROUND     = head.rnd;
  assign OUT_LANE_MASK = head.mask;
  assign OUT_ZERO      = head.zero;
  assign OUT_SUBN      = head.subn;
  assign OUT_INF       = head.inf;
  assign OUT_NAN       = head.nan;

endmodule

// File: tb/tb_fused_fp_add_issue.sv
// Directed self-checking bench for fused_fp_add_issue.
module tb_fused_fp_add_issue;

  logic        CLK = 1'b0;
  logic        RST, SYNC_CLR, IN_VALID, IN_READY, OUT_VALID, OUT_READY;
  logic [31:0] IN1, IN2, OUT_IN1, OUT_IN2;
  logic [2:0]  CONFIG_FP, ROUND_TYPE, OUT_CONFIG, OUT_ROUND;
  logic [3:0]  OUT_LANE_MASK;
  logic [7:0]  OUT_ZERO, OUT_SUBN, OUT_INF, OUT_NAN;

  int n_pass = 0;
  int n_chk  = 0;

  fused_fp_add_issue dut (
    .CLK(CLK), .RST(RST), .SYNC_CLR(SYNC_CLR), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN1(IN1), .IN2(IN2), .CONFIG_FP(CONFIG_FP), .ROUND_TYPE(ROUND_TYPE),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_IN1(OUT_IN1), .OUT_IN2(OUT_IN2),
    .OUT_CONFIG(OUT_CONFIG), .OUT_ROUND(OUT_ROUND), .OUT_LANE_MASK(OUT_LANE_MASK),
    .OUT_ZERO(OUT_ZERO), .OUT_SUBN(OUT_SUBN), .OUT_INF(OUT_INF), .OUT_NAN(OUT_NAN)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Push one pair into an empty stage, check the classified head, then pop it.
  task automatic push_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] cfg, input logic [3:0] mask,
                            input logic [7:0] zero, input logic [7:0] subn,
                            input logic [7:0] inf, input logic [7:0] nan);
    IN1 = a; IN2 = b; CONFIG_FP = cfg; ROUND_TYPE = 3'd2; IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    chk({tag, "_valid"}, 64'(OUT_VALID), 64'd1);
    chk({tag, "_in2"},   64'(OUT_IN2), 64'(b));
    chk({tag, "_round"}, 64'(OUT_ROUND), 64'd2);
    chk({tag, "_mask"},  64'(OUT_LANE_MASK), 64'(mask));
    chk({tag, "_zero"},  64'(OUT_ZERO), 64'(zero));
    chk({tag, "_subn"},  64'(OUT_SUBN), 64'(subn));
    chk({tag, "_inf"},   64'(OUT_INF), 64'(inf));
    chk({tag, "_nan"},   64'(OUT_NAN), 64'(nan));
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    chk({tag, "_popped"}, 64'(OUT_VALID), 64'd0);
  endtask

  initial begin
    RST = 1'b1; SYNC_CLR = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
    IN1 = '0; IN2 = '0; CONFIG_FP = '0; ROUND_TYPE = '0;
    #1;
    chk("rst_in_ready", 64'(IN_READY), 64'd1);
    chk("rst_out_valid", 64'(OUT_VALID), 64'd0);
    chk("rst_out_in1", 64'(OUT_IN1), 64'd0);
    chk("rst_zero", 64'(OUT_ZERO), 64'd0);
    tick(); tick();
    RST = 1'b0;
    tick();

    // Data without IN_VALID is ignored
    IN1 = 32'hDEADBEEF; IN2 = 32'h12345678;
    tick();
    chk("no_valid_ignored", 64'(OUT_VALID), 64'd0);

    push_check("fp32",    32'h3F800000, 32'h7F800000, 3'd0, 4'b0001, 8'h00, 8'h00, 8'h10, 8'h00);
    push_check("fp16",    32'h7C000000, 32'h7E008001, 3'd1, 4'b0101, 8'h01, 8'h10, 8'h04, 8'h40);
    push_check("bf16",    32'h7FC00001, 32'hFF800000, 3'd2, 4'b0101, 8'h10, 8'h01, 8'h40, 8'h04);
    push_check("e4m3",    32'h7F7E0080, 32'h00000000, 3'd3, 4'b1111, 8'hF3, 8'h00, 8'h00, 8'h08);
    push_check("e5m2",    32'h7F7E0080, 32'h00000000, 3'd4, 4'b1111, 8'hF3, 8'h00, 8'h00, 8'h0C);
    push_check("cfg_bad", 32'h7FC00000, 32'h00000001, 3'd7, 4'b0001, 8'h00, 8'h10, 8'h00, 8'h01);

    // Stall: A and B accepted, C held until space frees up
    CONFIG_FP = 3'd0; IN_VALID = 1'b1; IN1 = 32'hA; IN2 = 32'h0;
    tick();
    chk("stall_ready_occ1", 64'(IN_READY), 64'd1);
    IN1 = 32'hB;
    tick();
    chk("stall_ready_occ2", 64'(IN_READY), 64'd0);
    chk("stall_head_a", 64'(OUT_IN1), 64'hA);
    IN1 = 32'hC;
    tick(); tick();
    chk("stall_a_stable", 64'(OUT_IN1), 64'hA);
    chk("stall_c_held", 64'(IN_READY), 64'd0);
    OUT_READY = 1'b1;
    tick();
    chk("drain_b", 64'(OUT_IN1), 64'hB);
    chk("drain_ready", 64'(IN_READY), 64'd1);
    tick();
    IN_VALID = 1'b0;
    chk("drain_c", 64'(OUT_IN1), 64'hC);
    chk("drain_c_valid", 64'(OUT_VALID), 64'd1);
    tick();
    chk("drain_empty", 64'(OUT_VALID), 64'd0);
    OUT_READY = 1'b0;

    // Occupancy 1: simultaneous push D and pop
    IN_VALID = 1'b1; IN1 = 32'h1;
    tick();
    IN1 = 32'hD; OUT_READY = 1'b1;
    tick();
    IN_VALID = 1'b0; OUT_READY = 1'b0;
    chk("pushpop_head_d", 64'(OUT_IN1), 64'hD);
    chk("pushpop_ready", 64'(IN_READY), 64'd1);
    chk("pushpop_valid", 64'(OUT_VALID), 64'd1);
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    chk("pushpop_occ1", 64'(OUT_VALID), 64'd0);

    // SYNC_CLR at occupancy 2 drops the simultaneous push
    IN_VALID = 1'b1; IN1 = 32'h11;
    tick();
    IN1 = 32'h22;
    tick();
    chk("clr_full", 64'(IN_READY), 64'd0);
    IN1 = 32'h33; SYNC_CLR = 1'b1;
    tick();
    SYNC_CLR = 1'b0; IN_VALID = 1'b0;
    chk("clr_valid", 64'(OUT_VALID), 64'd0);
    chk("clr_ready", 64'(IN_READY), 64'd1);
    tick();
    chk("clr_dropped", 64'(OUT_VALID), 64'd0);

    // Asynchronous reset mid-stream
    IN_VALID = 1'b1; IN1 = 32'h7FC00000; CONFIG_FP = 3'd0;
    tick();
    IN_VALID = 1'b0;
    chk("arst_pre_nan", 64'(OUT_NAN), 64'h01);
    #1 RST = 1'b1;
    #1;
    chk("arst_valid", 64'(OUT_VALID), 64'd0);
    chk("arst_in1", 64'(OUT_IN1), 64'd0);
    chk("arst_nan", 64'(OUT_NAN), 64'd0);
    chk("arst_mask", 64'(OUT_LANE_MASK), 64'd0);
    tick();
    RST = 1'b0;
    tick();
    chk("arst_ready", 64'(IN_READY), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
